clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised multi-channel clock-enable generator, fully synchronous to CLK_24M.
//  Each channel divides the master clock by a run-time programmable integer N (odd or even).
//  Each channel outputs a duty-shaped level plus one-cycle rise/fall enables, so downstream
//    logic (LSPC, CPU and sound timing) stays on CLK_24M instead of using derived clocks.
//  RESYNC and per-channel enable align phases to video or system events.
// PARAMETERS
//  NUM_CH    2            number of divider channels (1..16)
//  CNT_W     8            divisor/counter width; max divisor 2**CNT_W-1
//  DIV_INIT  {8'd6,8'd3}  packed NUM_CH*CNT_W reset divisors, ch0 in LSBs (ch0=3 -> 8M, ch1=6 -> 4M)
//  CH_W      localparam   max(1,$clog2(NUM_CH))
// PORTS
//  CLK_24M  in   1            master clock; the only clock
//  nRESETP  in   1            reset, synchronous, active-low
//  RESYNC   in   1            realign all channels; effective at the same edge it is sampled
//  CH_EN    in   NUM_CH       per-channel run enable
//  DIV_WR   in   1            divisor write strobe (one cycle per write)
//  DIV_SEL  in   CH_W         target channel for DIV_WR
//  DIV_VAL  in   CNT_W        new divisor N
//  DIV_PEND out  NUM_CH       divisor staged but not yet applied, per channel
//  CLK_OUT  out  NUM_CH       divided level per channel
//  RISE_EN  out  NUM_CH       1-cycle pulse in the cycle CLK_OUT becomes 1
//  FALL_EN  out  NUM_CH       1-cycle pulse in the cycle CLK_OUT becomes 0
// BEHAVIOUR
//  - All outputs are registered. The reset state is a per-channel "parked" state:
//    DIV=DIV_INIT[ch], CNT=DIV-1, STAGE=DIV, DIV_PEND=0, CLK_OUT=0, RISE_EN=0, FALL_EN=0.
//  - Effective divisor Ne = (N<2) ? 2 : N. Clamping happens at write time, so DIV never holds 0 or 1.
//  - Running channel: CNT counts 0..Ne-1 and wraps. CLK_OUT=1 while CNT < H, where H=(Ne+1)>>1.
//    High time is ceil(Ne/2) cycles, low time floor(Ne/2). Example: N=3 gives 2 high / 1 low.
//  - RISE_EN=1 on the edge CNT enters 0. FALL_EN=1 on the edge CNT enters H. They never coincide.
//  - Start latency: the first active edge after reset release, RESYNC or CH_EN rising
//    moves CNT from Ne-1 to 0, so CLK_OUT=1 and RISE_EN=1 on that edge.
//  - Channels started together stay phase-locked. Rising edges coincide every lcm(Ne0,Ne1) cycles.
//  - Divisor write: when DIV_WR=1 and DIV_SEL<NUM_CH, then STAGE[sel]<=clamp(DIV_VAL) and DIV_PEND[sel]<=1.
//    DIV_SEL>=NUM_CH: the write is ignored and no state changes.
//    A second write before apply overwrites STAGE; the last write wins.
//  - Apply: on the edge where a running channel wraps (CNT==DIV-1 -> 0), DIV<=STAGE and DIV_PEND<=0.
//    The new period starts at that wrap. A period is never truncated or stretched (glitch-free).
//  - A write and a wrap on the same edge: the old STAGE is applied, the new value is staged, DIV_PEND stays 1.
//  - CH_EN[ch]=0: the channel parks. CNT=DIV-1 and CLK_OUT=0.
//    If CLK_OUT was 1, FALL_EN pulses once on the park edge. Any pending STAGE is applied immediately.
//  - RESYNC=1: every channel parks on that edge (same rules as CH_EN=0) and restarts on the
//    next edge with RESYNC=0 and CH_EN=1.
//    RESYNC held high keeps all channels parked.
//    RESYNC with DIV_WR on the same edge: the write is staged, then applied on the next edge.
//  - Reset mid-operation: the next edge returns every channel to the reset state. Staged writes are lost.
//  - Priority per edge: nRESETP=0 > RESYNC > CH_EN=0 > run.
// STRUCTURE
//  - Shared package neogeo_clk_pkg: CNT_W default, DIV_CLAMP_MIN=2, and the default master-clock
//    divisor constants DIV_8M=3, DIV_4M=6, DIV_12M=2.
//  - Sub-module clk_div_chan: one channel (CNT, DIV, STAGE, PEND, output regs), with inputs
//    run, wr, wr_val. The top decodes DIV_SEL and instantiates NUM_CH channels in a generate loop.
// TESTING
//  1. Reset with defaults, release: ch0 CLK_OUT pattern 1,1,0 repeating; ch1 1,1,1,0,0,0.
//     RISE_EN[0] and RISE_EN[1] coincide on the first edge and every 6 cycles thereafter.
//  2. Write DIV_SEL=0, DIV_VAL=5 mid-period: DIV_PEND[0]=1 until the wrap.
//     The old 3-cycle period completes, then the pattern is 1,1,1,0,0.
//  3. Write DIV_VAL=0 and, separately, DIV_VAL=1: each behaves as divide-by-2 (1,0 repeating).
//     DIV_SEL=3 with NUM_CH=2 changes no output.
//  4. Assert RESYNC for 1 cycle while CLK_OUT[1]=1: FALL_EN[1] pulses and both channels read 0.
//     Next edge: RISE_EN=2'b11.
//  5. Drop CH_EN[1] for 4 cycles with a write pending: STAGE is applied and DIV_PEND[1] clears on the park edge.
//     On re-enable, the rise comes 1 edge later with the new period.
//  6. Assert nRESETP=0 mid-period: after 1 edge all outputs are 0 and DIV_PEND=0.
//     The divisor reverts to DIV_INIT; a 255-cycle divisor is checked for wrap at CNT_W limit.

Source files
------------

// File: rtl/neogeo_clk_pkg.sv
// Shared constants for the NeoGeo master-clock enable generators.
//   CNT_W_DEFAULT : default divisor/counter width
//   DIV_CLAMP_MIN : smallest divisor a channel will hold (0 and 1 map to 2)
//   DIV_8M/4M/12M : CLK_24M divisors for the standard derived rates
package neogeo_clk_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned DIV_CLAMP_MIN = 2;

    localparam int unsigned DIV_8M  = 3;
    localparam int unsigned DIV_4M  = 6;
    localparam int unsigned DIV_12M = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One clock-enable divider channel running on CLK_24M.
//   CLK_24M  in   master clock
//   nRESETP  in   synchronous active-low reset
//   run      in   1 = count, 0 = park (CNT=DIV-1, CLK_OUT low)
//   wr       in   stage wr_val as the next divisor
//   wr_val   in   requested divisor (0/1 clamp to 2)
//   pend     out  staged divisor not yet applied
//   clk_out  out  divided level, high for ceil(N/2) cycles
//   rise_en  out  1-cycle pulse with clk_out going high
//   fall_en  out  1-cycle pulse with clk_out going low
module clk_div_chan
    import neogeo_clk_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_8M)
) (
    input  logic             CLK_24M,
    input  logic             nRESETP,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             pend,
    output logic             clk_out,
    output logic             rise_en,
    output logic             fall_en
);

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(DIV_CLAMP_MIN);
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT < DIV_MIN) ? DIV_MIN : DIV_INIT;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] stage;

    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] wr_clamped;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W-1:0] high_len;

    always_comb begin
        wr_clamped = (wr_val < DIV_MIN) ? DIV_MIN : wr_val;
        wrap       = (cnt == div - 1'b1);
        // A staged divisor takes effect at a period boundary or while parked,
        // so no period is ever cut short or stretched.
        apply      = pend && (!run || wrap);
        div_new    = apply ? stage : div;
        if (!run) begin
            cnt_new = div_new - 1'b1;
        end else if (wrap) begin
            cnt_new = '0;
        end else begin
            cnt_new = cnt + 1'b1;
        end
        // ceil(div/2) without overflowing at the all-ones divisor
        high_len = (div_new >> 1) + {{(CNT_W-1){1'b0}}, div_new[0]};
    end

    always_ff @(posedge CLK_24M) begin
        if (!nRESETP) begin
            div     <= DIV_RST;
            cnt     <= DIV_RST - 1'b1;
            stage   <= DIV_RST;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            rise_en <= 1'b0;
            fall_en <= 1'b0;
        end else begin
            div <= div_new;
            cnt <= cnt_new;
            // A write on the apply edge restages; the old stage is what got applied.
            if (wr) begin
                stage <= wr_clamped;
                pend  <= 1'b1;
            end else if (apply) begin
                pend  <= 1'b0;
            end
            if (run) begin
                clk_out <= (cnt_new < high_len);
                rise_en <= (cnt_new == '0);
                fall_en <= (cnt_new == high_len);
            end else begin
                clk_out <= 1'b0;
                rise_en <= 1'b0;
                fall_en <= clk_out;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator; every channel stays on CLK_24M.
//   CLK_24M   in   master clock
//   nRESETP   in   synchronous active-low reset
//   RESYNC    in   park all channels; they restart together on the next free edge
//   CH_EN     in   per-channel run enable
//   DIV_WR    in   divisor write strobe
//   DIV_SEL   in   channel addressed by DIV_WR (out of range: ignored)
//   DIV_VAL   in   new divisor
//   DIV_PEND  out  per-channel staged-divisor flag
//   CLK_OUT   out  per-channel divided level
//   RISE_EN   out  per-channel rising-edge enable
//   FALL_EN   out  per-channel falling-edge enable
module clk_div_multi
    import neogeo_clk_pkg::*;
#(
    parameter int unsigned              NUM_CH   = 2,
    parameter int unsigned              CNT_W    = CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT = {CNT_W'(DIV_4M), CNT_W'(DIV_8M)},
    localparam int unsigned             CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_24M,
    input  logic              nRESETP,
    input  logic              RESYNC,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_WR,
    input  logic [CH_W-1:0]   DIV_SEL,
    input  logic [CNT_W-1:0]  DIV_VAL,
    output logic [NUM_CH-1:0] DIV_PEND,
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] RISE_EN,
    output logic [NUM_CH-1:0] FALL_EN
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_run;
        logic ch_wr;

        // RESYNC parks exactly like CH_EN=0; equality decode drops out-of-range DIV_SEL.
        assign ch_run = CH_EN[i] & ~RESYNC;
        assign ch_wr  = DIV_WR & (DIV_SEL == CH_W'(i));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .CLK_24M (CLK_24M),
            .nRESETP (nRESETP),
            .run     (ch_run),
            .wr      (ch_wr),
            .wr_val  (DIV_VAL),
            .pend    (DIV_PEND[i]),
            .clk_out (CLK_OUT[i]),
            .rise_en (RISE_EN[i]),
            .fall_en (FALL_EN[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic       CLK_24M = 1'b0;
    logic       nRESETP;
    logic       RESYNC;
    logic [1:0] CH_EN;
    logic       DIV_WR;
    logic [0:0] DIV_SEL;
    logic [7:0] DIV_VAL;
    logic [1:0] DIV_PEND, CLK_OUT, RISE_EN, FALL_EN;

    logic [2:0] CH_EN3;
    logic       DIV_WR3;
    logic [1:0] DIV_SEL3;
    logic [7:0] DIV_VAL3;
    logic [2:0] DIV_PEND3, CLK_OUT3, RISE_EN3, FALL_EN3;

    int errors = 0;
    int checks = 0;

    always #5 CLK_24M = ~CLK_24M;

    clk_div_multi dut (
        .CLK_24M(CLK_24M), .nRESETP(nRESETP), .RESYNC(RESYNC), .CH_EN(CH_EN),
        .DIV_WR(DIV_WR), .DIV_SEL(DIV_SEL), .DIV_VAL(DIV_VAL),
        .DIV_PEND(DIV_PEND), .CLK_OUT(CLK_OUT), .RISE_EN(RISE_EN), .FALL_EN(FALL_EN)
    );

    clk_div_multi #(
        .NUM_CH   (3),
        .CNT_W    (8),
        .DIV_INIT ({8'd2, 8'd6, 8'd3})
    ) dut3 (
        .CLK_24M(CLK_24M), .nRESETP(nRESETP), .RESYNC(RESYNC), .CH_EN(CH_EN3),
        .DIV_WR(DIV_WR3), .DIV_SEL(DIV_SEL3), .DIV_VAL(DIV_VAL3),
        .DIV_PEND(DIV_PEND3), .CLK_OUT(CLK_OUT3), .RISE_EN(RISE_EN3), .FALL_EN(FALL_EN3)
    );

    task automatic tick;
        @(posedge CLK_24M);
        #1;
    endtask

    // Hold reset for two edges, then release; the next tick is start edge k=0.
    task automatic start;
        nRESETP = 1'b0; RESYNC = 1'b0; CH_EN = 2'b11; DIV_WR = 1'b0;
        DIV_SEL = 1'b0; DIV_VAL = 8'd0;
        CH_EN3 = 3'b111; DIV_WR3 = 1'b0; DIV_SEL3 = 2'd0; DIV_VAL3 = 8'd0;
        tick; tick;
        nRESETP = 1'b1;
    endtask

    task automatic test_reset;
        logic [1:0] ec, er, ef;
        start;
        nRESETP = 1'b0;
        tick;
        checks++; if (CLK_OUT !== 2'b00) begin errors++; $display("FAIL reset_clk: got %b want 00", CLK_OUT); end
        checks++; if (RISE_EN !== 2'b00) begin errors++; $display("FAIL reset_rise: got %b want 00", RISE_EN); end
        checks++; if (FALL_EN !== 2'b00) begin errors++; $display("FAIL reset_fall: got %b want 00", FALL_EN); end
        checks++; if (DIV_PEND !== 2'b00) begin errors++; $display("FAIL reset_pend: got %b want 00", DIV_PEND); end
        nRESETP = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            ec = {2'((k % 6) < 3), 1'b0} | {1'b0, 1'((k % 3) < 2)};
            er = {2'((k % 6) == 0), 1'b0} | {1'b0, 1'((k % 3) == 0)};
            ef = {2'((k % 6) == 3), 1'b0} | {1'b0, 1'((k % 3) == 2)};
            checks++; if (CLK_OUT !== ec) begin errors++; $display("FAIL default_clk k=%0d: got %b want %b", k, CLK_OUT, ec); end
            checks++; if (RISE_EN !== er) begin errors++; $display("FAIL default_rise k=%0d: got %b want %b", k, RISE_EN, er); end
            checks++; if (FALL_EN !== ef) begin errors++; $display("FAIL default_fall k=%0d: got %b want %b", k, FALL_EN, ef); end
        end
    endtask

    task automatic test_div_write;
        start;
        tick; tick;
        DIV_WR = 1'b1; DIV_SEL = 1'b0; DIV_VAL = 8'd5;
        tick;
        DIV_WR = 1'b0;
        checks++; if (DIV_PEND !== 2'b01) begin errors++; $display("FAIL wr_pend: got %b want 01", DIV_PEND); end
        checks++; if (CLK_OUT[0] !== 1'b0) begin errors++; $display("FAIL wr_oldperiod: got %b want 0", CLK_OUT[0]); end
        tick;
        checks++; if (DIV_PEND !== 2'b00) begin errors++; $display("FAIL wr_apply: got %b want 00", DIV_PEND); end
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tick;
            checks++; if (CLK_OUT[0] !== 1'((j % 5) < 3)) begin errors++; $display("FAIL div5_clk j=%0d: got %b", j, CLK_OUT[0]); end
            checks++; if (RISE_EN[0] !== 1'((j % 5) == 0)) begin errors++; $display("FAIL div5_rise j=%0d: got %b", j, RISE_EN[0]); end
            checks++; if (FALL_EN[0] !== 1'((j % 5) == 3)) begin errors++; $display("FAIL div5_fall j=%0d: got %b", j, FALL_EN[0]); end
            checks++; if (CLK_OUT[1] !== 1'(((j + 3) % 6) < 3)) begin errors++; $display("FAIL div5_ch1 j=%0d: got %b", j, CLK_OUT[1]); end
        end
    endtask

    task automatic test_div_clamp;
        logic [7:0] vals [2];
        int n;
        vals[0] = 8'd0; vals[1] = 8'd1;
        start;
        for (int v = 0; v < 2; v++) begin
            DIV_WR = 1'b1; DIV_SEL = 1'b0; DIV_VAL = vals[v];
            tick;
            DIV_WR = 1'b0;
            checks++; if (DIV_PEND[0] !== 1'b1) begin errors++; $display("FAIL clamp_pend v=%0d: got %b want 1", v, DIV_PEND[0]); end
            n = 0;
            while (DIV_PEND[0] !== 1'b0 && n < 8) begin tick; n++; end
            checks++; if (DIV_PEND[0] !== 1'b0) begin errors++; $display("FAIL clamp_timeout v=%0d: pend %b after %0d edges", v, DIV_PEND[0], n); end
            for (int j = 0; j < 6; j++) begin
                if (j > 0) tick;
                checks++; if (CLK_OUT[0] !== 1'((j % 2) == 0)) begin errors++; $display("FAIL clamp_clk v=%0d j=%0d: got %b", v, j, CLK_OUT[0]); end
                checks++; if (RISE_EN[0] !== 1'((j % 2) == 0)) begin errors++; $display("FAIL clamp_rise v=%0d j=%0d: got %b", v, j, RISE_EN[0]); end
                checks++; if (FALL_EN[0] !== 1'((j % 2) == 1)) begin errors++; $display("FAIL clamp_fall v=%0d j=%0d: got %b", v, j, FALL_EN[0]); end
            end
        end
        // Out-of-range select on a 3-channel instance (2-bit DIV_SEL can address 3).
        start;
        DIV_WR3 = 1'b1; DIV_SEL3 = 2'd3; DIV_VAL3 = 8'd5;
        for (int k = 0; k < 12; k++) begin
            tick;
            DIV_WR3 = 1'b0;
            checks++; if (DIV_PEND3 !== 3'b000) begin errors++; $display("FAIL badsel_pend k=%0d: got %b want 000", k, DIV_PEND3); end
            checks++;
            if (CLK_OUT3 !== {1'((k % 2) < 1), 1'((k % 6) < 3), 1'((k % 3) < 2)}) begin
                errors++; $display("FAIL badsel_clk k=%0d: got %b", k, CLK_OUT3);
            end
        end
        DIV_WR3 = 1'b1; DIV_SEL3 = 2'd2; DIV_VAL3 = 8'd4;
        tick;
        DIV_WR3 = 1'b0;
        checks++; if (DIV_PEND3 !== 3'b100) begin errors++; $display("FAIL sel2_pend: got %b want 100", DIV_PEND3); end
    endtask

    task automatic test_resync;
        start;
        tick; tick;
        RESYNC = 1'b1;
        tick;
        RESYNC = 1'b0;
        checks++; if (CLK_OUT !== 2'b00) begin errors++; $display("FAIL resync_clk: got %b want 00", CLK_OUT); end
        checks++; if (FALL_EN !== 2'b11) begin errors++; $display("FAIL resync_fall: got %b want 11", FALL_EN); end
        checks++; if (RISE_EN !== 2'b00) begin errors++; $display("FAIL resync_rise0: got %b want 00", RISE_EN); end
        tick;
        checks++; if (RISE_EN !== 2'b11) begin errors++; $display("FAIL resync_restart: got %b want 11", RISE_EN); end
        checks++; if (CLK_OUT !== 2'b11) begin errors++; $display("FAIL resync_restart_clk: got %b want 11", CLK_OUT); end
        for (int k = 1; k < 6; k++) begin
            tick;
            checks++;
            if (CLK_OUT !== {1'((k % 6) < 3), 1'((k % 3) < 2)}) begin errors++; $display("FAIL resync_pattern k=%0d: got %b", k, CLK_OUT); end
        end
        // Held RESYNC keeps everything parked.
        RESYNC = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (CLK_OUT !== 2'b00 || RISE_EN !== 2'b00) begin errors++; $display("FAIL resync_hold k=%0d: clk %b rise %b want 00", k, CLK_OUT, RISE_EN); end
        end
        // RESYNC and write on the same edge: staged now, applied at the restart.
        DIV_WR = 1'b1; DIV_SEL = 1'b1; DIV_VAL = 8'd4;
        tick;
        RESYNC = 1'b0; DIV_WR = 1'b0;
        checks++; if (DIV_PEND !== 2'b10) begin errors++; $display("FAIL resync_wr_pend: got %b want 10", DIV_PEND); end
        checks++; if (FALL_EN !== 2'b00) begin errors++; $display("FAIL resync_wr_fall: got %b want 00", FALL_EN); end
        tick;
        checks++; if (DIV_PEND !== 2'b00) begin errors++; $display("FAIL resync_wr_apply: got %b want 00", DIV_PEND); end
        checks++; if (RISE_EN !== 2'b11) begin errors++; $display("FAIL resync_wr_rise: got %b want 11", RISE_EN); end
        for (int j = 1; j < 8; j++) begin
            tick;
            checks++;
            if (CLK_OUT !== {1'((j % 4) < 2), 1'((j % 3) < 2)}) begin errors++; $display("FAIL resync_div4 j=%0d: got %b", j, CLK_OUT); end
        end
    endtask

    task automatic test_ch_en;
        start;
        DIV_WR = 1'b1; DIV_SEL = 1'b1; DIV_VAL = 8'd2;
        tick;
        DIV_WR = 1'b0;
        tick;
        checks++; if (DIV_PEND[1] !== 1'b1 || CLK_OUT[1] !== 1'b1) begin errors++; $display("FAIL chen_pre: pend %b clk %b want 1 1", DIV_PEND[1], CLK_OUT[1]); end
        CH_EN = 2'b01;
        tick;
        checks++; if (DIV_PEND[1] !== 1'b0) begin errors++; $display("FAIL chen_park_pend: got %b want 0", DIV_PEND[1]); end
        checks++; if (CLK_OUT[1] !== 1'b0) begin errors++; $display("FAIL chen_park_clk: got %b want 0", CLK_OUT[1]); end
        checks++; if (FALL_EN[1] !== 1'b1) begin errors++; $display("FAIL chen_park_fall: got %b want 1", FALL_EN[1]); end
        for (int k = 3; k < 6; k++) begin
            tick;
            checks++; if ({CLK_OUT[1], RISE_EN[1], FALL_EN[1]} !== 3'b000) begin errors++; $display("FAIL chen_parked k=%0d: got %b want 000", k, {CLK_OUT[1], RISE_EN[1], FALL_EN[1]}); end
        end
        CH_EN = 2'b11;
        for (int j = 0; j < 6; j++) begin
            tick;
            checks++; if (CLK_OUT[1] !== 1'((j % 2) == 0)) begin errors++; $display("FAIL chen_div2_clk j=%0d: got %b", j, CLK_OUT[1]); end
            checks++; if (RISE_EN[1] !== 1'((j % 2) == 0)) begin errors++; $display("FAIL chen_div2_rise j=%0d: got %b", j, RISE_EN[1]); end
            checks++; if (CLK_OUT[0] !== 1'(((j + 6) % 3) < 2)) begin errors++; $display("FAIL chen_ch0 j=%0d: got %b", j, CLK_OUT[0]); end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start;
        tick; tick; tick; tick;
        DIV_WR = 1'b1; DIV_SEL = 1'b0; DIV_VAL = 8'd7;
        tick;
        DIV_WR = 1'b0;
        checks++; if (DIV_PEND !== 2'b01) begin errors++; $display("FAIL mid_pend: got %b want 01", DIV_PEND); end
        nRESETP = 1'b0;
        tick;
        checks++;
        if ({CLK_OUT, RISE_EN, FALL_EN, DIV_PEND} !== 8'h00) begin
            errors++; $display("FAIL mid_reset: clk %b rise %b fall %b pend %b want all 0", CLK_OUT, RISE_EN, FALL_EN, DIV_PEND);
        end
        nRESETP = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++;
            if (CLK_OUT !== {1'((k % 6) < 3), 1'((k % 3) < 2)}) begin errors++; $display("FAIL mid_revert k=%0d: got %b", k, CLK_OUT); end
        end
        DIV_WR = 1'b1; DIV_SEL = 1'b0; DIV_VAL = 8'd255;
        tick;
        DIV_WR = 1'b0;
        n = 0;
        while (DIV_PEND[0] !== 1'b0 && n < 8) begin tick; n++; end
        checks++; if (DIV_PEND[0] !== 1'b0) begin errors++; $display("FAIL d255_timeout: pend %b after %0d edges", DIV_PEND[0], n); end
        for (int j = 0; j < 257; j++) begin
            if (j > 0) tick;
            checks++; if (CLK_OUT[0] !== 1'((j % 255) < 128)) begin errors++; $display("FAIL d255_clk j=%0d: got %b", j, CLK_OUT[0]); end
            checks++; if (RISE_EN[0] !== 1'((j % 255) == 0)) begin errors++; $display("FAIL d255_rise j=%0d: got %b", j, RISE_EN[0]); end
            checks++; if (FALL_EN[0] !== 1'((j % 255) == 128)) begin errors++; $display("FAIL d255_fall j=%0d: got %b", j, FALL_EN[0]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_div_write;
        test_div_clamp;
        test_resync;
        test_ch_en;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
